tick_counter: RTL

- Synchronous modulo counter driven by an internal clock-enable prescaler.
- Lab stage directly downstream of the half-adder cell: the counter's next-state increment is a WIDTH-stage ripple chain of half_adder instances.
- Carry-in to the chain is the prescaler tick.
- Output Q feeds display/decoder logic; tc feeds cascaded counters.

---
 rtl/tick_counter.sv | 82 ++++++++
 1 files changed

// File: rtl/tick_counter.sv
// Prescaled modulo counter (0..MAX) whose increment path is a ripple chain of
// half adders; the prescaler tick is the chain carry-in.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

module tick_counter #(
  parameter int WIDTH = 4,
  parameter int DIV   = 4,
  parameter int MAX   = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             tick,
  output logic             tc,
  output logic             ovf
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]    DIV_LAST = DW'(DIV - 1);
  localparam logic [WIDTH-1:0] QMAX     = WIDTH'(MAX);

  logic [DW-1:0]    div_cnt;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] q_nxt;
  logic             at_max;
  logic             unused_carry_out;

  function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
    return (v > QMAX) ? QMAX : v;
  endfunction

  assign tick   = en & (div_cnt == DIV_LAST) & ~reset;
  assign at_max = (Q == QMAX);
  assign tc     = tick & at_max;

  // Increment by tick: the chain's sum equals Q when tick is low.
  assign carry[0] = tick;
  for (genvar i = 0; i < WIDTH; i++) begin : g_inc
    half_adder u_ha (
      .a  (Q[i]),
      .b  (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end
  assign unused_carry_out = carry[WIDTH];

  always_comb begin
    q_nxt = sum;
    if (tc) q_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      Q       <= '0;
      div_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      if (en) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      // A load discards any coincident tick, so no wrap is recorded.
      if (load) begin
        Q <= sat_load(D);
      end else begin
        Q <= q_nxt;
        if (tc) ovf <= 1'b1;
      end
    end
  end
endmodule
